// File: rtl/bsg_manycore_ep_req_arbiter.sv
// Round-robin arbiter sharing one endpoint request FIFO port among several
// requesters. A grant is held across a locked burst (capped at max_burst_p
// packets), issue is gated on the adapter's outstanding-credit count, and one
// IDLE cycle always separates consecutive grants.
module bsg_manycore_ep_req_arbiter #(
  parameter int num_req_p               = 4,
  parameter int fifo_width_p            = 128,
  parameter int max_out_credits_p       = 32,
  parameter int max_burst_p             = 4,
  parameter int credit_counter_width_lp = $clog2(max_out_credits_p + 1),
  parameter int req_id_width_lp         = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               en_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p-1:0]               req_lock_i,
  input  logic [num_req_p*fifo_width_p-1:0]  req_data_i,
  output logic [num_req_p-1:0]               req_ready_o,
  input  logic [credit_counter_width_lp-1:0] out_credits_i,
  output logic                               endpoint_req_v_o,
  output logic [fifo_width_p-1:0]            endpoint_req_data_o,
  input  logic                               endpoint_req_ready_i,
  output logic                               grant_v_o,
  output logic [req_id_width_lp-1:0]         grant_id_o,
  output logic                               busy_o
);

  localparam int burst_w_lp = (max_burst_p > 1) ? $clog2(max_burst_p) : 1;
  // Count value of the last packet a locked grant may send before release.
  localparam logic [burst_w_lp-1:0] burst_last_lp = burst_w_lp'(max_burst_p - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [req_id_width_lp-1:0] grant_id_q, grant_id_d;
  logic [req_id_width_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [burst_w_lp-1:0]      burst_cnt_q, burst_cnt_d;

  logic                       pick_v;
  logic [req_id_width_lp-1:0] pick_id;
  logic                       in_grant;
  logic                       credit_ok;
  logic                       gnt_req_v;
  logic                       gnt_req_lock;
  logic                       handshake;

  // Index 'off' positions after 'base', wrapping modulo num_req_p.
  function automatic logic [req_id_width_lp-1:0] wrap_add(
    input logic [req_id_width_lp-1:0] base,
    input int                         off
  );
    int s;
    s = int'(base) + off;
    if (s >= num_req_p) s = s - num_req_p;
    return req_id_width_lp'(s);
  endfunction

  // Round-robin pick: scan from the far end so the nearest valid to rr_ptr wins.
  always_comb begin
    pick_v  = 1'b0;
    pick_id = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (req_v_i[wrap_add(rr_ptr_q, i)]) begin
        pick_v  = 1'b1;
        pick_id = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign in_grant     = (state_q == GRANT);
  assign credit_ok    = (out_credits_i != '0);
  assign gnt_req_v    = req_v_i[grant_id_q];
  assign gnt_req_lock = req_lock_i[grant_id_q];

  assign endpoint_req_v_o    = in_grant & gnt_req_v & credit_ok;
  assign endpoint_req_data_o = endpoint_req_v_o
                             ? req_data_i[grant_id_q*fifo_width_p +: fifo_width_p]
                             : '0;
  assign handshake           = endpoint_req_v_o & endpoint_req_ready_i;

  // Ready goes only to the held grant, and only when a credit is available.
  always_comb begin
    req_ready_o = '0;
    if (in_grant & endpoint_req_ready_i & credit_ok) begin
      req_ready_o[grant_id_q] = 1'b1;
    end
  end

  assign grant_v_o  = in_grant;
  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q != IDLE);

  // Next-state: grant in IDLE, then hold through a locked burst or release.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en_i && pick_v) begin
          grant_id_d = pick_id;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (handshake && gnt_req_lock && (burst_cnt_q < burst_last_lp)) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (handshake || !gnt_req_v) begin
          // Normal end of grant, burst cap reached, or lock abandoned.
          burst_cnt_d = '0;
          rr_ptr_d    = wrap_add(grant_id_q, 1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter FSM state registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_ep_req_arbiter.sv
// Bench for bsg_manycore_ep_req_arbiter: requesters hold queues of messages,
// a queue-level round-robin model predicts the packet order, and a monitor
// checks every handshake plus per-cycle output rules.
module tb_bsg_manycore_ep_req_arbiter;

  localparam int N  = 4;
  localparam int W  = 128;
  localparam int CW = 6;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            en;
  logic [N-1:0]    req_v;
  logic [N-1:0]    req_lock;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic [CW-1:0]   out_credits;
  logic            ep_v;
  logic [W-1:0]    ep_data;
  logic            ep_ready;
  logic            grant_v;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  bsg_manycore_ep_req_arbiter #(
    .num_req_p(N), .fifo_width_p(W), .max_out_credits_p(32), .max_burst_p(MB)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
    .req_v_i(req_v), .req_lock_i(req_lock), .req_data_i(req_data),
    .req_ready_o(req_ready), .out_credits_i(out_credits),
    .endpoint_req_v_o(ep_v), .endpoint_req_data_o(ep_data),
    .endpoint_req_ready_i(ep_ready),
    .grant_v_o(grant_v), .grant_id_o(grant_id), .busy_o(busy)
  );

  typedef struct packed { logic [W-1:0] data; logic lock; } pkt_t;
  typedef struct packed { logic [W-1:0] data; logic [1:0] id; logic last; } exp_t;

  pkt_t rq[N][$];
  pkt_t mq[N][$];
  exp_t expq[$];

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;
  bit mon_en = 1'b0;
  logic [N-1:0] hs_mask = '0;

  bit         exp_idle = 0, exp_hold = 0, exp_stay_idle = 0, exp_pick = 0;
  logic [1:0] hold_id = '0, pick_exp = '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    logic [N-1:0] exp_rdy;
    if (mon_en && reset_n) begin
      hs_mask = '0;
      if (exp_idle) chk("gap_idle", grant_v, 1'b0);
      if (exp_hold) begin
        chk("burst_hold_v", grant_v, 1'b1);
        chk("burst_hold_id", grant_id, hold_id);
      end
      if (exp_stay_idle) chk("en_low_idle", grant_v, 1'b0);
      if (exp_pick) begin
        chk("issue_v", grant_v, 1'b1);
        chk("issue_id", grant_id, pick_exp);
      end
      exp_idle = 0; exp_hold = 0; exp_stay_idle = 0; exp_pick = 0;

      chk("ready_onehot0", $onehot0(req_ready), 1'b1);
      chk("busy", busy, grant_v);
      if (grant_v) begin
        exp_v = req_v[grant_id] && (out_credits != 0);
        exp_rdy = (ep_ready && out_credits != 0) ? (N'(1) << grant_id) : '0;
        chk("ep_v", ep_v, exp_v);
        chk("req_ready", req_ready, exp_rdy);
      end else begin
        chk("idle_ep_v", ep_v, 1'b0);
        chk("idle_req_ready", req_ready, '0);
      end
      if (!ep_v) chk("data_zero", ep_data, '0);

      if (ep_v && ep_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_packet actual=%h required=none", ep_data);
        end else begin
          e = expq.pop_front();
          chk("pkt_id", grant_id, e.id);
          chk("pkt_data", ep_data, e.data);
          if (e.last) exp_idle = 1;
          else begin exp_hold = 1; hold_id = e.id; end
        end
        hs_mask[grant_id] = 1'b1;
      end

      if (!grant_v) begin
        if (!en) exp_stay_idle = 1;
        else if ((|req_v) && expq.size() != 0) begin
          exp_pick = 1;
          pick_exp = expq[0].id;
        end
      end
    end
  end

  // Stimulus and reference model.
  initial begin
    int g, c, n, cyc, nmsg, len;
    bit last, busy_q;
    pkt_t p;
    logic [W-1:0] d;

    reset_n = 1'b0; en = 1'b1; req_v = '1; req_lock = '0;
    req_data = '1; out_credits = CW'(32); ep_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ep_v", ep_v, 1'b0);
    chk("rst_ep_data", ep_data, '0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_grant_v", grant_v, 1'b0);
    chk("rst_grant_id", grant_id, '0);
    chk("rst_busy", busy, 1'b0);
    req_v = '0; req_data = '0;
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;

    for (int r = 0; r < 8; r++) begin
      // Build per-requester message queues; locks high except on each message's last packet.
      for (int i = 0; i < N; i++) begin
        nmsg = (r == 0) ? 1 : $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = (r == 0) ? 1 : $urandom_range(1, 7);
          for (int k = 0; k < len; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            d[127:126] = 2'(i);
            p.data = d;
            p.lock = (k != len - 1);
            rq[i].push_back(p);
          end
        end
        mq[i] = rq[i];
      end
      // Queue-level round robin: each turn sends one capped burst.
      forever begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          c = (model_ptr + k) % N;
          if (g < 0 && mq[c].size() != 0) g = c;
        end
        if (g < 0) break;
        n = 0;
        do begin
          p = mq[g].pop_front();
          n++;
          last = !(p.lock && n < MB);
          expq.push_back({p.data, 2'(g), last});
        end while (!last);
        model_ptr = (g + 1) % N;
      end

      cyc = 0;
      forever begin
        busy_q = (expq.size() != 0);
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) busy_q = 1;
        if (!busy_q || cyc >= 3000) break;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (hs_mask[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        for (int i = 0; i < N; i++) begin
          req_v[i] = (rq[i].size() != 0);
          req_lock[i] = (rq[i].size() != 0) ? rq[i][0].lock : 1'b0;
          req_data[i*W +: W] = (rq[i].size() != 0) ? rq[i][0].data : '0;
        end
        en = (r == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
        out_credits = (r != 0 && $urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom_range(1, 32));
        ep_ready = (r == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (cyc >= 3000) begin
        failures++;
        $display("FAIL round_timeout actual=%0d required=%0d", expq.size(), 0);
      end
      checks++;
      if (expq.size() != 0) begin
        failures++;
        $display("FAIL round_drained actual=%0d required=0", expq.size());
        expq.delete();
      end
    end

    // Reset during an active grant, after steering rr_ptr away from 0.
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    en = 1'b1; out_credits = CW'(5); req_lock = '0; ep_ready = 1'b1;
    req_v = 4'b0100; req_data = '0; req_data[2*W +: W] = {4{32'hA5A5_0002}};
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(ep_v && ep_ready) && cyc < 20);
    chk("pre_reset_hs", ep_v & ep_ready, 1'b1);
    @(posedge clk);
    #1;
    ep_ready = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!ep_v && cyc < 20);
    chk("pre_reset_v", ep_v, 1'b1);
    chk("pre_reset_id", grant_id, 2'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_ep_v", ep_v, 1'b0);
    chk("midrst_req_ready", req_ready, '0);
    chk("midrst_grant_v", grant_v, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_data", ep_data, '0);
    req_v = 4'b1010;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_grant_v", grant_v, 1'b1);
    chk("post_rst_grant_id", grant_id, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_ep_req_arbiter.md
Name: bsg_manycore_ep_req_arbiter

Overview:
- Round-robin arbiter that shares the 128-bit endpoint request FIFO port of a manycore endpoint-to-FIFO adapter between num_req_p requesters (DPI tile emulators, host-side injectors, trace replayers).
- Gates issue on the adapter's outstanding-credit count.
- Supports locked bursts so multi-packet transactions are never interleaved.
- Sits between the requesters and the endpoint_req_{data,v,ready} interface of the adapter.

Parameters:
- num_req_p, 4, number of requesters; must be >= 2.
- fifo_width_p, 128, packet width in bits.
- max_out_credits_p, 32, credit depth of the endpoint.
- max_burst_p, 4, maximum consecutive packets under one locked grant; must be >= 1.
- credit_counter_width_lp, $clog2(max_out_credits_p+1), derived.
- req_id_width_lp, `BSG_SAFE_CLOG2(num_req_p), derived.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  permits new grants; an in-progress grant or burst always completes.
- req_v_i  in  num_req_p  per-requester valid. Once asserted it must hold until its handshake.
- req_lock_i  in  num_req_p  per-requester: more packets follow; keep the grant.
- req_data_i  in  num_req_p*fifo_width_p  per-requester packets; requester i occupies bits [i*fifo_width_p +: fifo_width_p].
- req_ready_o  out  num_req_p  one-hot ready back to the granted requester.
- out_credits_i  in  credit_counter_width_lp  free credits from the endpoint.
- endpoint_req_v_o  out  1  valid to the endpoint request FIFO.
- endpoint_req_data_o  out  fifo_width_p  packet to the endpoint.
- endpoint_req_ready_i  in  1  endpoint accepts.
- grant_v_o  out  1  a grant is held.
- grant_id_o  out  req_id_width_lp  index of the held grant.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - state=IDLE; rr_ptr=0; grant_id_r=0; burst_cnt=0.
  - All outputs 0, including req_ready_o, endpoint_req_v_o and endpoint_req_data_o.
  - Reset asserted mid-burst drops endpoint_req_v_o in the same cycle. A packet in flight that cycle is not considered sent.
- States:
  - IDLE:
    - If en_i=1 and |req_v_i, pick the first set req_v_i at or after rr_ptr, wrapping modulo num_req_p.
    - Register grant_id_r and go to GRANT.
    - Issue latency from req_v_i rise to endpoint_req_v_o rise is 1 cycle.
  - GRANT:
    - endpoint_req_v_o = req_v_i[grant_id_r] & (out_credits_i != 0).
    - endpoint_req_data_o = req_data_i[grant_id_r] (combinational mux). It is 0 whenever endpoint_req_v_o=0.
    - req_ready_o[grant_id_r] = endpoint_req_ready_i & (out_credits_i != 0); all other bits are 0.
    - Handshake fires when endpoint_req_v_o & endpoint_req_ready_i.
    - On a handshake, if req_lock_i[grant_id_r]=1 and burst_cnt < max_burst_p-1: burst_cnt++ and stay in GRANT.
    - Otherwise on a handshake: burst_cnt=0, rr_ptr=(grant_id_r+1) mod num_req_p, go to IDLE.
    - If req_v_i[grant_id_r] deasserts in GRANT without a handshake (lock abandoned after a burst packet): burst_cnt=0, rr_ptr advances as above, go to IDLE.
- Burst cap:
  - With max_burst_p=4, a requester holding lock sends at most 4 packets back-to-back.
  - The grant is then released even though lock is still high.
  - Others arbitrate first; the capped requester re-competes normally.
- Credits:
  - out_credits_i=0 stalls issue while keeping the grant; no state change.
  - The arbiter never decrements credits itself; the adapter owns the count.
- en_i=0 in GRANT has no effect until the grant is released. en_i=0 in IDLE holds IDLE.
- Invariants:
  - grant_v_o = (state==GRANT); grant_id_o = grant_id_r.
  - req_ready_o is one-hot or zero.
  - The IDLE cycle between grants is mandatory, so peak throughput is 1 packet/cycle within a burst and 1 packet/2 cycles across grants.
  - The rr_ptr wrap from num_req_p-1 goes to 0.

Test Plan:
- Reset release, all four req_v_i high, locks 0, credits=32 → grants in order 0,1,2,3,0, each packet on endpoint_req_data_o tagged with its requester id. Each grant's handshake is followed by exactly 1 IDLE cycle.
- Requester 2 with lock=1 for 6 packets, requester 0 also valid, credits=32 → packets 2,2,2,2 (cap 4), then 0, then 2,2.
- Grant to 1, out_credits_i held 0 for 5 cycles then 1 → endpoint_req_v_o=0 and req_ready_o=0 for 5 cycles, then a single handshake; grant_id_o stays 1 throughout.
- endpoint_req_ready_i low for 3 cycles during a 3-packet burst from requester 3 → data stable, no packet dropped or duplicated; exactly 3 handshakes.
- en_i dropped mid-burst (requester 0, lock=1, 3 packets) → burst completes, then IDLE persists while en_i=0 despite req_v_i=4'b1111; issue resumes 1 cycle after en_i=1 with requester 1.
- reset_n_i pulsed low during GRANT with endpoint_req_v_o=1 → endpoint_req_v_o, req_ready_o and grant_v_o are 0 immediately. After release, the first grant goes to the lowest valid index from rr_ptr=0.
